alu_logic_result_stage: RTL and testbench
=========================================

Name: alu_logic_result_stage

Overview:
- Registered downstream stage for the 16-bit bitwise logic units (NAND, AND, OR, XOR).
- Selects one unit result per the operation select and computes zero/negative flags.
- Holds the result in a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU datapath feeds the MCU writeback without combinational backpressure paths.
- Also counts delivered results for debug.

Parameters:
- WIDTH, 16, data width of unit results and the output result.
- CNT_W, 8, width of the delivered-result counter.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- IN_VALID  input  1  upstream holds a valid operation/result set.
- IN_READY  output  1  stage can accept; registered, no combinational path from OUT_READY.
- OPSEL  input  2  00=NAND, 01=AND, 10=OR, 11=XOR.
- NAND_IN  input  WIDTH  NAND unit output.
- AND_IN  input  WIDTH  AND unit output.
- OR_IN  input  WIDTH  OR unit output.
- XOR_IN  input  WIDTH  XOR unit output.
- OUT_VALID  output  1  RES/flags valid.
- OUT_READY  input  1  downstream accepts.
- RES  output  WIDTH  selected result.
- ZF  output  1  RES == 0.
- NF  output  1  RES[WIDTH-1].
- PF  output  1  even parity of RES (only with PARITY_FLAG_EN, else tied 0).
- RES_CNT  output  CNT_W  count of completed output handshakes.

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - OUT_VALID=0, IN_READY=1, RES=0, ZF=0, NF=0, PF=0, RES_CNT=0.
  - Both buffer entries empty.
  - Reset mid-transfer discards any buffered entries with no output handshake; RES_CNT clears the same cycle.
- Handshake:
  - An input transfer occurs when IN_VALID && IN_READY at a rising edge.
  - An output transfer occurs when OUT_VALID && OUT_READY.
  - RES, ZF, NF and PF hold stable while OUT_VALID && !OUT_READY.
- Entry capture:
  - On input transfer the selected value sel = mux(OPSEL) is captured.
  - Flags are computed from sel at capture time and stored with the entry.
- Latency: one cycle from input transfer to OUT_VALID when the output register is empty.
- States (buffer occupancy):
  - EMPTY: IN_READY=1, OUT_VALID=0. On input transfer → ONE (result into output register).
  - ONE: IN_READY=1, OUT_VALID=1.
    - Input+output same cycle: new result into output register, stay ONE.
    - Output only → EMPTY.
    - Input only → FULL (new result into skid register).
  - FULL: IN_READY=0, OUT_VALID=1. On output transfer, skid moves to output register → ONE. Inputs ignored.
- Ordering: results leave strictly in acceptance order; no drops, no duplicates.
- IN_READY is a flop-driven function of state only.
- Counter: RES_CNT increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
- Unknown OPSEL is not possible (2-bit, all codes defined).

Optional Feature:
- Macro: PARITY_FLAG_EN.
- Defined: PF = ~^RES, i.e. 1 when RES has an even number of ones. PF is stored per entry and reset to 0.
- Undefined: no parity logic; PF is driven constant 0.

Test Plan:
- Reset, then IN_VALID=1, OPSEL=00, NAND_IN=16'hFFFF, OUT_READY=1 → next cycle OUT_VALID=1, RES=16'hFFFF, ZF=0, NF=1, PF=1 (with macro); RES_CNT=1 after the handshake.
- OPSEL=01, AND_IN=16'h0000 → RES=0, ZF=1, NF=0.
- Backpressure:
  - Setup: OUT_READY=0; stream results 16'h0001, 16'h0002, 16'h0003.
  - Expected: the first two are accepted; IN_READY=0 on the third.
  - Release: raise OUT_READY → outputs in order 0001, 0002, then 0003; IN_READY returns to 1 after the first release cycle.
- Continuous streaming: IN_VALID=1, OUT_READY=1 for 10 cycles, OPSEL cycling 00..11 with distinct inputs → one result per cycle, correct mux selection, RES_CNT=10.
- Reset with FULL buffer (OUT_READY=0), assert RST one cycle → OUT_VALID=0, IN_READY=1, RES_CNT=0; no stale entry appears afterward.
- Preload RES_CNT to 255 by 255 transfers (CNT_W=8), one more transfer → RES_CNT=0.

Source files
------------

// File: rtl/alu_logic_result_stage.sv
// Result stage for the 16-bit logic units: selects a unit result, computes flags,
// and buffers it in a 2-entry skid buffer. Optional macro PARITY_FLAG_EN enables PF.
module alu_logic_result_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OPSEL,
    input  logic [WIDTH-1:0] NAND_IN,
    input  logic [WIDTH-1:0] AND_IN,
    input  logic [WIDTH-1:0] OR_IN,
    input  logic [WIDTH-1:0] XOR_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RES,
    output logic             ZF,
    output logic             NF,
    output logic             PF,
    output logic [CNT_W-1:0] RES_CNT
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zf;
        logic             nf;
        logic             pf;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state;
    entry_t           out_q;
    entry_t           skid_q;
    entry_t           cap;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] sel;

    // Unit select and flag generation for the entry being captured
    always_comb begin
        sel = '0;
        case (OPSEL)
            2'b00:   sel = NAND_IN;
            2'b01:   sel = AND_IN;
            2'b10:   sel = OR_IN;
            default: sel = XOR_IN;
        endcase
        cap.res = sel;
        cap.zf  = (sel == '0);
        cap.nf  = sel[WIDTH-1];
`ifdef PARITY_FLAG_EN
        cap.pf  = ~^sel;
`else
        cap.pf  = 1'b0;
`endif
    end

    assign in_xfer  = IN_VALID && in_ready_q;
    assign out_xfer = out_valid_q && OUT_READY;

    // Occupancy FSM; IN_READY and OUT_VALID are registered from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (out_xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        out_q       <= cap;
                        state       <= S_ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_q <= cap;
                    end else if (out_xfer) begin
                        state       <= S_EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else if (in_xfer) begin
                        skid_q     <= cap;
                        state      <= S_FULL;
                        in_ready_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (out_xfer) begin
                        out_q      <= skid_q;
                        state      <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign RES       = out_q.res;
    assign ZF        = out_q.zf;
    assign NF        = out_q.nf;
    assign PF        = out_q.pf;
    assign RES_CNT   = cnt_q;

endmodule

// File: tb/tb_alu_logic_result_stage.sv
// Scoreboard bench for alu_logic_result_stage: expected entries are queued on
// input acceptance and compared at each output handshake.
module tb_alu_logic_result_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  OPSEL;
    logic [15:0] NAND_IN;
    logic [15:0] AND_IN;
    logic [15:0] OR_IN;
    logic [15:0] XOR_IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] RES;
    logic        ZF;
    logic        NF;
    logic        PF;
    logic [7:0]  RES_CNT;

    typedef struct packed {
        logic [15:0] res;
        logic        zf;
        logic        nf;
        logic        pf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_logic_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OPSEL(OPSEL),
        .NAND_IN(NAND_IN), .AND_IN(AND_IN), .OR_IN(OR_IN), .XOR_IN(XOR_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RES(RES), .ZF(ZF), .NF(NF), .PF(PF), .RES_CNT(RES_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] c,
                                   input logic [15:0] d);
        exp_t e;
        logic [15:0] v;
        v = (op == 2'b00) ? a : (op == 2'b01) ? b : (op == 2'b10) ? c : d;
        e.res = v;
        e.zf  = (v == 16'h0000);
        e.nf  = v[15];
`ifdef PARITY_FLAG_EN
        e.pf  = ~^v;
`else
        e.pf  = 1'b0;
`endif
        return e;
    endfunction

    // Output handshake completes at the next rising edge; compare against the oldest entry
    always @(negedge CLK) begin
        if (RST === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            if (q.size() == 0) begin
                check("sb_unexpected_output", 32'(RES), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_res", 32'(RES), 32'(e.res));
                check("sb_zf",  32'(ZF),  32'(e.zf));
                check("sb_nf",  32'(NF),  32'(e.nf));
                check("sb_pf",  32'(PF),  32'(e.pf));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        IN_VALID = 1'b1;
        OPSEL    = op;
        NAND_IN  = a;
        AND_IN   = b;
        OR_IN    = c;
        XOR_IN   = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1) begin
                q.push_back(model(op, a, b, c, d));
                @(posedge CLK);
                #1;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0) return;
            @(posedge CLK);
            #1;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        q.delete();
    endtask

    initial begin
        int c0;
        int c1;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        OPSEL     = 2'b00;
        NAND_IN   = '0;
        AND_IN    = '0;
        OR_IN     = '0;
        XOR_IN    = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        check("rst_res",       32'(RES),       32'd0);
        check("rst_zf",        32'(ZF),        32'd0);
        check("rst_nf",        32'(NF),        32'd0);
        check("rst_pf",        32'(PF),        32'd0);
        check("rst_cnt",       32'(RES_CNT),   32'd0);

        // First result: one-cycle latency, counter after handshake
        OUT_READY = 1'b1;
        send(2'b00, 16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC);
        idle();
        check("lat_out_valid", 32'(OUT_VALID), 32'd1);
        check("lat_res",       32'(RES),       32'h0000_FFFF);
        check("lat_cnt",       32'(RES_CNT),   32'd0);
        @(posedge CLK);
        #1;
        check("cnt_after_first", 32'(RES_CNT), 32'd1);

        send(2'b01, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF);
        idle();
        drain();

        // Backpressure: two accepted, third stalled, release in order
        OUT_READY = 1'b0;
        send(2'b10, 16'h0, 16'h0, 16'h0001, 16'h0);
        send(2'b10, 16'h0, 16'h0, 16'h0002, 16'h0);
        check("bp_full_in_ready",  32'(IN_READY),  32'd0);
        check("bp_full_out_valid", 32'(OUT_VALID), 32'd1);
        IN_VALID = 1'b1;
        OR_IN    = 16'h0003;
        repeat (2) @(posedge CLK);
        #1;
        check("bp_stall_in_ready", 32'(IN_READY), 32'd0);
        check("bp_hold_res",       32'(RES),      32'h0000_0001);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_release_in_ready", 32'(IN_READY), 32'd1);
        send(2'b10, 16'h0, 16'h0, 16'h0003, 16'h0);
        idle();
        drain();

        // Continuous streaming, one accept per cycle
        do_reset();
        OUT_READY = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            send(2'(i % 4), 16'h1000 + 16'(i), 16'h2000 + 16'(i),
                 16'h4000 + 16'(i), 16'h8000 + 16'(i));
        end
        c1 = cyc;
        idle();
        check("stream_cycles", 32'(c1 - c0), 32'd10);
        drain();
        check("stream_cnt", 32'(RES_CNT), 32'd10);

        // Reset while full discards both entries
        OUT_READY = 1'b0;
        send(2'b11, 16'h0, 16'h0, 16'h0, 16'hAAAA);
        send(2'b11, 16'h0, 16'h0, 16'h0, 16'h5555);
        idle();
        check("full_before_rst", 32'(IN_READY), 32'd0);
        do_reset();
        check("rst_full_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_full_in_ready",  32'(IN_READY),  32'd1);
        check("rst_full_cnt",       32'(RES_CNT),   32'd0);
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("no_stale_out_valid", 32'(OUT_VALID), 32'd0);

        // Counter wrap at 2^8
        for (int i = 0; i < 255; i++) begin
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
        end
        idle();
        drain();
        check("cnt_255", 32'(RES_CNT), 32'd255);
        send(2'b01, 16'h0, 16'h8001, 16'h0, 16'h0);
        idle();
        drain();
        check("cnt_wrap", 32'(RES_CNT), 32'd0);

        check("sb_empty_at_end", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
